uart_tx_buffered: RTL
=====================

Name: uart_tx_buffered

Overview:
Downstream consumer of the core's 9-bit console output strobe {valid, byte}. It buffers characters in a small FIFO and serialises them onto a real 8N1 asynchronous TX line. This replaces the simulation-only print sink for FPGA builds. The core never stalls on console writes, so the block absorbs bursts and flags loss with a sticky overflow bit.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit (>=2)
FIFO_DEPTH, 16, buffer entries (power of two, >=2)
ADDR_W, 4, log2(FIFO_DEPTH)

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
uart_in  in  9  bit 8 = write strobe, bits 7:0 = character; one char per cycle that bit 8 is high
tx  out  1  serial line, idle high
busy  out  1  high while frame in progress or FIFO non-empty
fifo_count  out  ADDR_W+1  entries currently stored (0..FIFO_DEPTH)
overflow  out  1  sticky: a strobe arrived while FIFO full and no pop that cycle

Behaviour:
- Reset (async, reset_n=0): tx=1, busy=0, fifo_count=0, overflow=0, FSM=IDLE, pointers=0, bit/baud counters=0. Reset mid-frame aborts immediately; tx returns high asynchronously.
- FIFO: circular, wr_ptr/rd_ptr ADDR_W bits wrapping modulo FIFO_DEPTH; count tracked separately (ADDR_W+1 bits).
- Push: uart_in[8]=1 and (count<FIFO_DEPTH or pop same cycle) -> store uart_in[7:0] at wr_ptr, wr_ptr++.
- Full and strobe with no simultaneous pop -> byte dropped, overflow<=1 (held until reset).
- Simultaneous push+pop -> count unchanged; push accepted even when full.
- Pop only from IDLE when count>0; pop in the same cycle as a push into an empty FIFO is not allowed (data appears next cycle).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If count>0: load shift reg from rd_ptr, rd_ptr++, baud_cnt=0 -> START.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA, bit_idx=0.
  - DATA: tx=shift[0]; after CLKS_PER_BIT cycles shift right, bit_idx++; after bit_idx 7 completes -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles -> IDLE.
- Timing: strobe sampled at edge N; FIFO holds byte after N; IDLE pops at edge N+1; tx falls after edge N+1 (registered output, glitch-free). Frame = 10*CLKS_PER_BIT cycles; back-to-back frames separated by exactly one IDLE cycle.
- LSB first. tx is a flop output, never combinational.
- busy = (FSM!=IDLE) | (count!=0).
- baud_cnt counts 0..CLKS_PER_BIT-1; transition on terminal count.

Optional Feature:
UART_TX_PARITY_EN: when defined, FSM gains PARITY state between DATA and STOP; tx = even parity (XOR of 8 data bits) for CLKS_PER_BIT cycles; frame = 11*CLKS_PER_BIT cycles. When undefined, 8N1 frame as above with no PARITY state.

Test Plan:
- Reset then idle 100 cycles -> tx=1, busy=0, fifo_count=0, overflow=0.
- Single strobe 0x41 ('A'), CLKS_PER_BIT=16 -> tx low 16 cycles starting one cycle after the strobe edge, then bits 1,0,0,0,0,0,1,0 (16 cycles each), stop high 16; busy drops after 160 cycles.
- Burst of 16 consecutive strobes 0x30..0x3F -> fifo_count peaks at 15 (first byte popped), no overflow; line decodes "0123456789:;<=>?" in order with one idle cycle between frames.
- Burst of 20 consecutive strobes -> bytes beyond capacity dropped, overflow=1 sticky, delivered bytes are an in-order prefix without corruption.
- Assert reset_n low at the mid-DATA bit with 3 entries queued -> tx=1 immediately, fifo_count=0; after release, no residual frames.
- With UART_TX_PARITY_EN, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; frame length 176 cycles.

Source files
------------

// File: rtl/uart_tx_buffered_if.sv
// Console byte-stream bundle between the core's output strobe and the buffered UART transmitter.
interface uart_tx_buffered_if #(
  parameter int ADDR_W = 4
);
  logic [8:0]      uart_in;
  logic            tx;
  logic            busy;
  logic [ADDR_W:0] fifo_count;
  logic            overflow;

  modport master (output uart_in, input tx, busy, fifo_count, overflow);
  modport slave  (input uart_in, output tx, busy, fifo_count, overflow);
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter fed by a never-stalling {valid, byte} console strobe.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  uart_tx_buffered_if.slave bus
);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t            state_q, state_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic              tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic       strobe;
  logic       full;
  logic       pop;
  logic       push;
  logic       baud_last;
  logic [7:0] rd_data;

  assign strobe    = bus.uart_in[8];
  assign full      = (count_q == COUNT_FULL);
  // A push into an empty FIFO is never popped the same cycle: pop looks at the registered count.
  assign pop       = (state_q == S_IDLE) && (count_q != '0);
  assign push      = strobe && (!full || pop);
  assign baud_last = (baud_q == BAUD_LAST);
  assign rd_data   = mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    baud_d     = baud_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (strobe && full && !pop) begin
      overflow_d = 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + COUNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - COUNT_ONE;
    end

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d  = rd_data;
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          baud_d   = '0;
          state_d  = S_START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^rd_data;
`endif
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level follows the next state so tx is a clean flop aligned with the FSM.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      baud_q     <= '0;
      tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      baud_q     <= baud_d;
      tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // Storage array carries no reset so it can map onto RAM.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.uart_in[7:0];
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = (state_q != S_IDLE) || (count_q != '0);
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;
endmodule
